// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 block: CP0 move/eret decode, EPC/Status/Block/Cause registers,
// and edge-triggered exception capture that loads EPC with the faulting PC.
module cp0_exception_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCin,
  input  logic [31:0] Din,
  input  logic        ExpSrc0,
  input  logic        ExpSrc1,
  input  logic        ExpSrc2,
  output logic [31:0] PCout,
  output logic [31:0] Dout,
  output logic        ExRegWrite,
  output logic        ExpBlock,
  output logic        IsEret,
  output logic        HasExp
);

  typedef enum logic [1:0] {
    SEL_EPC    = 2'b00,
    SEL_STATUS = 2'b01,
    SEL_BLOCK  = 2'b10,
    SEL_CAUSE  = 2'b11
  } cp0_sel_e;

  logic [31:0] epc, status, block, cause;
  logic        pending, req_d;
  cp0_sel_e    sel;
  logic        wen, req, trig;
  logic [2:0]  src, masked;
  logic        unused_instr_bits;

  assign ExRegWrite = ~Instruction[23];
  assign IsEret     = (Instruction[5:0] == 6'b011000);
  assign sel        = cp0_sel_e'(Instruction[12:11]);
  assign wen        = enable & ~ExRegWrite;

  assign src    = {ExpSrc2, ExpSrc1, ExpSrc0};
  assign masked = src & ~block[2:0];
  assign req    = (|masked) & ~status[0];
  assign trig   = req & ~req_d & ~pending;

  assign PCout    = epc;
  assign ExpBlock = status[0];
  assign HasExp   = pending;

  assign unused_instr_bits = ^{Instruction[31:24], Instruction[22:13], Instruction[10:6]};

  always_comb begin
    Dout = '0;
    case (sel)
      SEL_EPC:    Dout = epc;
      SEL_STATUS: Dout = status;
      SEL_BLOCK:  Dout = block;
      SEL_CAUSE:  Dout = cause;
      default:    Dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epc     <= '0;
      status  <= '0;
      block   <= '0;
      cause   <= '0;
      pending <= 1'b0;
      req_d   <= 1'b0;
    end else begin
      req_d <= req;
      if (trig) begin
        pending <= 1'b1;
        cause   <= {29'b0, ExpSrc2, ExpSrc1 | ExpSrc2, ExpSrc0 | ExpSrc1 | ExpSrc2};
      end
      // exception EPC load wins over a same-cycle software EPC write
      if (pending) begin
        epc     <= PCin;
        pending <= 1'b0;
      end else if (wen && sel == SEL_EPC) begin
        epc <= Din;
      end
      if (wen && sel == SEL_STATUS) status <= Din;
      if (wen && sel == SEL_BLOCK)  block  <= Din;
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] Instruction, PCin, Din;
  logic        ExpSrc0, ExpSrc1, ExpSrc2;
  logic [31:0] PCout, Dout;
  logic        ExRegWrite, ExpBlock, IsEret, HasExp;

  int unsigned errors = 0;
  int unsigned checks = 0;

  cp0_exception_unit dut (
    .clk(clk), .reset(reset), .enable(enable), .Instruction(Instruction),
    .PCin(PCin), .Din(Din), .ExpSrc0(ExpSrc0), .ExpSrc1(ExpSrc1), .ExpSrc2(ExpSrc2),
    .PCout(PCout), .Dout(Dout), .ExRegWrite(ExRegWrite), .ExpBlock(ExpBlock),
    .IsEret(IsEret), .HasExp(HasExp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; Instruction = 32'h40000000;
    PCin = '0; Din = '0; ExpSrc0 = 1'b0; ExpSrc1 = 1'b0; ExpSrc2 = 1'b0;
    tick();
    reset = 1'b0;

    // reset state
    for (int unsigned s = 0; s < 4; s++) begin
      Instruction = 32'h40000000 | (s << 11);
      #1 check($sformatf("rst_dout_sel%0d", s), Dout, 32'h0);
    end
    check("rst_pcout", PCout, 32'h0);
    check("rst_hasexp", {31'b0, HasExp}, 32'h0);
    check("rst_expblock", {31'b0, ExpBlock}, 32'h0);

    // decode
    Instruction = 32'h42000018; #1;
    check("dec_eret", {31'b0, IsEret}, 32'h1);
    Instruction = 32'h40800000; #1;
    check("dec_mtc0_rw", {31'b0, ExRegWrite}, 32'h0);
    Instruction = 32'h40000000; #1;
    check("dec_mfc0_rw", {31'b0, ExRegWrite}, 32'h1);
    check("dec_mfc0_eret", {31'b0, IsEret}, 32'h0);

    // exception on ExpSrc2
    ExpSrc2 = 1'b1; PCin = 32'h11111111;
    tick();
    check("exc_hasexp", {31'b0, HasExp}, 32'h1);
    PCin = 32'h12345678;
    tick();
    check("exc_hasexp_drop", {31'b0, HasExp}, 32'h0);
    check("exc_epc", PCout, 32'h12345678);
    Instruction = 32'h40001800; #1;
    check("exc_cause", Dout, 32'h7);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check($sformatf("exc_held%0d", i), {31'b0, HasExp}, 32'h0);
    end
    ExpSrc2 = 1'b0;
    tick();

    // mask via Block[0]
    Instruction = 32'h40801000; Din = 32'h1; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("blk_readback", Dout, 32'h1);
    ExpSrc0 = 1'b1;
    tick();
    check("blk_masked0", {31'b0, HasExp}, 32'h0);
    ExpSrc0 = 1'b0;
    tick();
    check("blk_masked1", {31'b0, HasExp}, 32'h0);

    // mask via Status[0]
    Instruction = 32'h40800800; Din = 32'h1; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("sts_expblock", {31'b0, ExpBlock}, 32'h1);
    ExpSrc1 = 1'b1;
    tick();
    check("sts_masked", {31'b0, HasExp}, 32'h0);
    ExpSrc1 = 1'b0;
    tick();

    // clear masks, ExpSrc0 fires with Cause = 1
    Instruction = 32'h40800800; Din = 32'h0; enable = 1'b1;
    tick();
    Instruction = 32'h40801000;
    tick();
    enable = 1'b0;
    check("unmask_expblock", {31'b0, ExpBlock}, 32'h0);
    ExpSrc0 = 1'b1; PCin = 32'h00000040;
    tick();
    check("src0_hasexp", {31'b0, HasExp}, 32'h1);
    Instruction = 32'h40001800; #1;
    check("src0_cause", Dout, 32'h1);
    tick();
    ExpSrc0 = 1'b0;
    check("src0_epc", PCout, 32'h00000040);
    tick();

    // software EPC write
    Instruction = 32'h40800000; Din = 32'hFEEDFACE; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("sw_epc", PCout, 32'hFEEDFACE);

    // collision: exception load beats mtc0 EPC
    ExpSrc1 = 1'b1; PCin = 32'h0;
    tick();
    check("col_hasexp", {31'b0, HasExp}, 32'h1);
    Instruction = 32'h40800000; Din = 32'hCAFEBABE; enable = 1'b1; PCin = 32'h87654321;
    tick();
    enable = 1'b0;
    check("col_epc", PCout, 32'h87654321);
    Instruction = 32'h40001800; #1;
    check("col_cause", Dout, 32'h3);
    ExpSrc1 = 1'b0;
    tick();

    // reset mid-sequence
    ExpSrc0 = 1'b1; PCin = 32'hAAAA5555;
    tick();
    check("rst_mid_hasexp", {31'b0, HasExp}, 32'h1);
    reset = 1'b1; ExpSrc0 = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_mid_cleared", {31'b0, HasExp}, 32'h0);
    check("rst_mid_epc", PCout, 32'h0);
    tick();
    check("rst_mid_noload", PCout, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
